fxp_requant_scheduler: RTL and testbench

- Shares one signed fixed-point requantizer between N_REQ requesters in the adaptive-filter datapath, e.g. filter output, error term and coefficient update.
- Each requester has a runtime-programmable shift register that sets its input-to-output scaling.
- A round-robin arbiter grants one request per cycle into a single registered output stage with valid/ready backpressure.
- Rounding is truncation (floor); overflow either wraps or saturates (see Optional Feature).

---
 rtl/fxp_requant_scheduler.sv | 122 ++++++++++++
 tb/tb_fxp_requant_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_requant_scheduler.sv
// Round-robin shared signed fixed-point requantizer with a registered valid/ready output stage.
// Optional macro FXP_REQUANT_SAT_EN: saturate instead of wrap on overflow.
module fxp_requant_scheduler #(
   parameter int unsigned N_REQ      = 3,
   parameter int unsigned DIN_WIDTH  = 32,
   parameter int          DIN_FRAC   = 30,
   parameter int unsigned DOUT_WIDTH = 16,
   parameter int          DOUT_FRAC  = 15,
   parameter int unsigned SHIFT_W    = 6,
   localparam int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DIN_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       cfg_we,
   input  logic [ID_W-1:0]            cfg_sel,
   input  logic [SHIFT_W-1:0]         cfg_shift,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DOUT_WIDTH-1:0]      out_data,
   output logic [ID_W-1:0]            out_id,
   output logic                       out_ovf
);

   // Wide enough that the largest left shift loses no bits.
   localparam int unsigned EXT_W = DIN_WIDTH + 2**(SHIFT_W-1);
   localparam logic [SHIFT_W-1:0] SHIFT_RST = SHIFT_W'(DIN_FRAC - DOUT_FRAC);

   logic [SHIFT_W-1:0]    r_shift [N_REQ];
   logic [ID_W-1:0]       r_ptr;
   logic                  r_valid;
   logic [DOUT_WIDTH-1:0] r_data;
   logic [ID_W-1:0]       r_id;
   logic                  r_ovf;

   logic                  w_can_accept;
   logic                  w_gnt_vld;
   logic [ID_W-1:0]       w_gnt_idx;
   logic [DIN_WIDTH-1:0]  w_x;
   logic [SHIFT_W-1:0]    w_s;
   logic [SHIFT_W-1:0]    w_mag;
   logic signed [EXT_W-1:0] w_x_ext;
   logic signed [EXT_W-1:0] w_y;
   logic                  w_ovf;
   logic [DOUT_WIDTH-1:0] w_res;

   assign w_can_accept = !r_valid || out_ready;

   always_comb begin : arb
      int unsigned idx;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      idx       = 0;
      if (w_can_accept) begin
         for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(r_ptr) + k) % N_REQ;
            if (!w_gnt_vld && req_valid[idx]) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = ID_W'(idx);
            end
         end
      end
   end

   assign req_ready = w_gnt_vld ? (N_REQ'(1) << w_gnt_idx) : '0;

   always_comb begin
      w_x     = req_data[w_gnt_idx*DIN_WIDTH +: DIN_WIDTH];
      w_s     = r_shift[w_gnt_idx];
      w_mag   = -w_s;
      w_x_ext = {{(EXT_W-DIN_WIDTH){w_x[DIN_WIDTH-1]}}, w_x};
      if (w_s[SHIFT_W-1]) w_y = w_x_ext <<< w_mag;
      else                w_y = w_x_ext >>> w_s;
      // Representable iff all bits above the output sign bit replicate it.
      w_ovf = (w_y[EXT_W-1:DOUT_WIDTH-1] != {(EXT_W-DOUT_WIDTH+1){w_y[EXT_W-1]}});
`ifdef FXP_REQUANT_SAT_EN
      if (w_ovf) begin
         w_res = w_y[EXT_W-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end else begin
         w_res = w_y[DOUT_WIDTH-1:0];
      end
`else
      w_res = w_y[DOUT_WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= ID_W'(N_REQ - 1);
         r_valid <= 1'b0;
         r_data  <= '0;
         r_id    <= '0;
         r_ovf   <= 1'b0;
      end else if (w_gnt_vld) begin
         r_ptr   <= w_gnt_idx;
         r_valid <= 1'b1;
         r_data  <= w_res;
         r_id    <= w_gnt_idx;
         r_ovf   <= w_ovf;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) r_shift[i] <= SHIFT_RST;
      end else if (cfg_we) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (cfg_sel == ID_W'(i)) r_shift[i] <= cfg_shift;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_id    = r_id;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_fxp_requant_scheduler.sv
// Self-checking bench for fxp_requant_scheduler: directed scenarios plus randomized traffic
// against a behavioural arithmetic/arbitration model.
module tb_fxp_requant_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [5:0]  cfg_shift;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_id;
   logic        out_ovf;

   int errors = 0;
   int checks = 0;

   // Model state
   logic        m_valid;
   logic [15:0] m_data;
   logic [1:0]  m_id;
   logic        m_ovf;
   int          m_ptr;
   int          m_shift [3];
   int          m_gnt;

   fxp_requant_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_shift (cfg_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // y = floor(x * 2^-s), range-checked against a 16-bit signed result.
   function automatic void requant(input logic [31:0] x, input int s,
                                   output logic [15:0] d, output logic ovf);
      longint y;
      y = longint'($signed(x));
      if (s >= 0) y = y >>> s;
      else        y = y * (longint'(1) << (-s));
      ovf = (y > 32767) || (y < -32768);
      d = 16'(y);
`ifdef FXP_REQUANT_SAT_EN
      if (y > 32767)  d = 16'h7FFF;
      if (y < -32768) d = 16'h8000;
`endif
   endfunction

   function automatic int pick(input logic [2:0] v, input int ptr);
      for (int k = 1; k <= 3; k++) begin
         if (v[(ptr + k) % 3]) return (ptr + k) % 3;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_id = '0; m_ovf = 1'b0; m_ptr = 2; m_gnt = -1;
      for (int i = 0; i < 3; i++) m_shift[i] = 15;
   endtask

   // One clock: entered and left at posedge+1.
   task automatic step(input string tag);
      int g;
      logic [2:0]  exp_rdy;
      logic [15:0] d;
      logic        o;
      #4;
      g = (!m_valid || out_ready) ? pick(req_valid, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s req_ready got=%b exp=%b", tag, req_ready, exp_rdy);
      end
      @(posedge clk);
      if (g >= 0) begin
         requant(req_data[g*32 +: 32], m_shift[g], d, o);
         m_valid = 1'b1; m_data = d; m_id = 2'(g); m_ovf = o; m_ptr = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      if (cfg_we && cfg_sel < 3) m_shift[cfg_sel] = $signed(cfg_shift);
      m_gnt = g;
      #1;
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_id !== m_id || out_ovf !== m_ovf) begin
         errors++;
         $display("FAIL %s out got v=%b d=%h id=%0d ovf=%b exp v=%b d=%h id=%0d ovf=%b", tag,
                  out_valid, out_data, out_id, out_ovf, m_valid, m_data, m_id, m_ovf);
      end
   endtask

   task automatic send(input int id, input logic [31:0] x, input string tag);
      bit done = 0;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_data[id*32 +: 32] = x;
      out_ready = 1'b1;
      for (int n = 0; n < 10 && !done; n++) begin
         step(tag);
         if (m_gnt == id) done = 1;
      end
      req_valid[id] = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s no grant got=none exp=req%0d", tag, id);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] d, input logic [1:0] id,
                            input logic ovf);
      checks++;
      if (out_valid !== 1'b1 || out_data !== d || out_id !== id || out_ovf !== ovf) begin
         errors++;
         $display("FAIL %s got v=%b d=%h id=%0d ovf=%b exp v=1 d=%h id=%0d ovf=%b", tag,
                  out_valid, out_data, out_id, out_ovf, d, id, ovf);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || out_id !== 2'd0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset out got v=%b d=%h id=%0d ovf=%b exp all zero",
                  out_valid, out_data, out_id, out_ovf);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid = '0; req_data = '0; cfg_we = 0; cfg_sel = 0; cfg_shift = 0; out_ready = 1;
      rst_n = 1'b1;
      #1;
      do_reset();
      step("reset_idle");
   endtask

   task automatic test_basic();
      send(0, 32'h2000_0000, "basic0");
      check_out("basic0_val", 16'h4000, 2'd0, 1'b0);
      send(1, 32'hE000_0000, "basic1");
      check_out("basic1_val", 16'hC000, 2'd1, 1'b0);
   endtask

   task automatic test_truncation();
      send(0, 32'h0000_7FFF, "trunc_pos");
      check_out("trunc_pos_val", 16'h0000, 2'd0, 1'b0);
      send(1, 32'hFFFF_FFFF, "trunc_neg");
      check_out("trunc_neg_val", 16'hFFFF, 2'd1, 1'b0);
   endtask

   task automatic test_overflow();
      send(2, 32'h4000_0000, "ovf_pos");
`ifdef FXP_REQUANT_SAT_EN
      check_out("ovf_pos_val", 16'h7FFF, 2'd2, 1'b1);
`else
      check_out("ovf_pos_val", 16'h8000, 2'd2, 1'b1);
`endif
      send(0, 32'hBFFF_FFFF, "ovf_neg");
`ifdef FXP_REQUANT_SAT_EN
      check_out("ovf_neg_val", 16'h8000, 2'd0, 1'b1);
`else
      check_out("ovf_neg_val", 16'h7FFF, 2'd0, 1'b1);
`endif
   endtask

   task automatic test_rotation();
      logic [15:0] hd;
      logic [1:0]  hid;
      do_reset();
      req_data = {32'h1000_0000, 32'hF000_0000, 32'h0800_0000};
      req_valid = 3'b111;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step("rot");
         checks++;
         if (out_id !== 2'(k % 3)) begin
            errors++;
            $display("FAIL rot_seq[%0d] out_id got=%0d exp=%0d", k, out_id, k % 3);
         end
      end
      hd = out_data; hid = out_id;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step("stall");
         checks++;
         if (req_ready !== 3'b000 || out_data !== hd || out_id !== hid || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall[%0d] got rdy=%b d=%h id=%0d v=%b exp rdy=000 d=%h id=%0d v=1",
                     k, req_ready, out_data, out_id, out_valid, hd, hid);
         end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step("resume");
         checks++;
         if (out_id !== 2'(k)) begin
            errors++;
            $display("FAIL resume_seq[%0d] out_id got=%0d exp=%0d", k, out_id, k);
         end
      end
      req_valid = '0;
      step("rot_drain");
   endtask

   task automatic test_config();
      cfg_we = 1; cfg_sel = 2; cfg_shift = 6'h3E;
      step("cfg_wr");
      cfg_we = 0;
      send(2, 32'h0000_1000, "cfg_left");
      check_out("cfg_left_val", 16'h4000, 2'd2, 1'b0);
      cfg_we = 1; cfg_sel = 2; cfg_shift = 6'd0;
      send(2, 32'h0000_0800, "cfg_coinc");
      cfg_we = 0;
      check_out("cfg_coinc_old", 16'h2000, 2'd2, 1'b0);
      send(2, 32'h0000_0800, "cfg_new");
      check_out("cfg_new_val", 16'h0800, 2'd2, 1'b0);
      cfg_we = 1; cfg_sel = 3; cfg_shift = 6'd5;
      step("cfg_bad_sel");
      cfg_we = 0;
      send(0, 32'h2000_0000, "cfg_bad_chk");
      check_out("cfg_bad_val", 16'h4000, 2'd0, 1'b0);
   endtask

   task automatic test_random();
      req_valid = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!req_valid[i] && ($urandom % 2 == 0)) begin
               req_valid[i] = 1'b1;
               req_data[i*32 +: 32] = ($urandom % 4 == 0) ? $urandom
                                      : 32'($signed($urandom) >>> $urandom_range(0, 20));
            end
         end
         out_ready = ($urandom % 4 != 0);
         cfg_we    = ($urandom % 8 == 0);
         cfg_sel   = 2'($urandom_range(0, 3));
         cfg_shift = 6'($urandom_range(0, 28) - 8);
         step("random");
         if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
      end
      cfg_we = 0; req_valid = '0; out_ready = 1;
      step("random_drain");
   endtask

   task automatic test_reset_mid();
      cfg_we = 1; cfg_sel = 0; cfg_shift = 6'h3E;
      step("mid_cfg");
      cfg_we = 0;
      req_data[32 +: 32] = 32'h1234_5678;
      req_valid = 3'b010;
      out_ready = 1'b0;
      step("mid_load");
      req_valid = '0;
      step("mid_hold");
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset out_valid got=%b exp=0", out_valid);
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      req_data = {32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
      req_valid = 3'b111;
      out_ready = 1'b1;
      step("mid_after");
      check_out("mid_after_val", 16'h4000, 2'd0, 1'b0);
      req_valid = '0;
      step("mid_drain");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_overflow();
      test_rotation();
      test_config();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
